// File: rtl/intt_ctrl_pkg.sv
// Shared constants and FSM state encoding for the iNTT stream controller.
// Latency: none (declarations only).
// Backpressure: not applicable.
package intt_ctrl_pkg;

    localparam int INTT_N = 8;      // coefficients per transform
    localparam int INTT_W = 12;     // coefficient width
    localparam int Q      = 3329;   // modulus used by the attached datapath

    typedef logic [1:0] state_t;

    localparam state_t ST_LOAD  = 2'd0;
    localparam state_t ST_FIRE  = 2'd1;
    localparam state_t ST_WAIT  = 2'd2;
    localparam state_t ST_DRAIN = 2'd3;

endpackage

// File: rtl/intt_frame_buf.sv
// N x W coefficient register file: indexed write, whole-vector load, full-vector read.
// Latency: writes visible the cycle after the enable; reads are combinational.
// Backpressure: none; the owner decides when to write.
module intt_frame_buf #(
    parameter int N  = 8,
    parameter int W  = 12,
    parameter int IW = $clog2(N)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                wr_en_i,
    input  logic [IW-1:0]       wr_idx_i,
    input  logic [W-1:0]        wr_dat_i,
    input  logic                ld_en_i,
    input  logic [N-1:0][W-1:0] ld_vec_i,
    output logic [N-1:0][W-1:0] vec_o
);

    logic [N-1:0][W-1:0] mem_q;

    // Storage: reset clears, a bulk load beats a single-entry write.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q <= '0;
        end else if (ld_en_i) begin
            mem_q <= ld_vec_i;
        end else if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_dat_i;
        end
    end

    assign vec_o = mem_q;

endmodule

// File: rtl/intt_stream_ctrl.sv
// Streams N coefficients in, fires the external iNTT datapath once, streams N results out.
// Latency: last input beat to first output beat is 2 + datapath valid latency.
// Backpressure: s_ready only in LOAD; m_data holds while m_ready is low; WAIT aborts after TIMEOUT cycles.
module intt_stream_ctrl
    import intt_ctrl_pkg::*;
#(
    parameter int W       = INTT_W,
    parameter int N       = INTT_N,
    parameter int TIMEOUT = 32
) (
    input  logic                clk,
    input  logic                r,
    input  logic                s_valid,
    input  logic [W-1:0]        s_data,
    output logic                s_ready,
    output logic                m_valid,
    output logic [W-1:0]        m_data,
    input  logic                m_ready,
    output logic [N-1:0][W-1:0] dp_coeffs,
    output logic                dp_valid_in,
    input  logic [N-1:0][W-1:0] dp_coeffs_out,
    input  logic                dp_valid_out,
    output logic                busy,
    output logic                err,
    input  logic                err_clr,
    output logic [15:0]         frames_done
);

    localparam int IW = $clog2(N);
    localparam int CW = $clog2(TIMEOUT);

    state_t              state_q, state_d;
    logic [IW-1:0]       load_idx_q, load_idx_d;
    logic [IW-1:0]       drain_idx_q, drain_idx_d;
    logic [CW-1:0]       wait_cnt_q, wait_cnt_d;
    logic                dpv_prev_q;
    logic                err_q, err_d;
    logic [15:0]         frames_q, frames_d;
    logic                timeout;
    logic                s_fire, m_fire, dpv_edge, capture;
    logic [N-1:0][W-1:0] in_vec, out_vec;

    // Handshakes are gated by reset so no beat is exchanged while r is high.
    assign s_ready     = ~r & (state_q == ST_LOAD);
    assign m_valid     = ~r & (state_q == ST_DRAIN);
    assign dp_valid_in = ~r & (state_q == ST_FIRE);
    assign m_data      = r ? '0 : out_vec[drain_idx_q];
    assign busy        = (state_q != ST_LOAD);
    assign err         = err_q;
    assign frames_done = frames_q;
    assign dp_coeffs   = in_vec;

    assign s_fire   = s_valid & s_ready;
    assign m_fire   = m_valid & m_ready;
    // Only a fresh rising edge counts, so a level left high from before WAIT is ignored.
    assign dpv_edge = dp_valid_out & ~dpv_prev_q;
    assign capture  = (state_q == ST_WAIT) & dpv_edge;

    intt_frame_buf #(.N(N), .W(W)) u_in_buf (
        .clk_i    (clk),
        .rst_i    (r),
        .wr_en_i  (s_fire),
        .wr_idx_i (load_idx_q),
        .wr_dat_i (s_data),
        .ld_en_i  (1'b0),
        .ld_vec_i ('0),
        .vec_o    (in_vec)
    );

    intt_frame_buf #(.N(N), .W(W)) u_out_buf (
        .clk_i    (clk),
        .rst_i    (r),
        .wr_en_i  (1'b0),
        .wr_idx_i ('0),
        .wr_dat_i ('0),
        .ld_en_i  (capture),
        .ld_vec_i (dp_coeffs_out),
        .vec_o    (out_vec)
    );

    // Next-state logic for the LOAD -> FIRE -> WAIT -> DRAIN frame sequence.
    always_comb begin
        state_d     = state_q;
        load_idx_d  = load_idx_q;
        drain_idx_d = drain_idx_q;
        wait_cnt_d  = wait_cnt_q;
        frames_d    = frames_q;
        timeout     = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (s_fire) begin
                    if (load_idx_q == IW'(N - 1)) begin
                        load_idx_d = '0;
                        state_d    = ST_FIRE;
                    end else begin
                        load_idx_d = load_idx_q + IW'(1);
                    end
                end
            end
            ST_FIRE: begin
                wait_cnt_d = '0;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (dpv_edge) begin
                    wait_cnt_d = '0;
                    state_d    = ST_DRAIN;
                end else if (wait_cnt_q == CW'(TIMEOUT - 1)) begin
                    // Abandon the frame; the result never arrived.
                    wait_cnt_d = '0;
                    timeout    = 1'b1;
                    state_d    = ST_LOAD;
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
            default: begin
                if (m_fire) begin
                    if (drain_idx_q == IW'(N - 1)) begin
                        drain_idx_d = '0;
                        frames_d    = frames_q + 16'd1;
                        state_d     = ST_LOAD;
                    end else begin
                        drain_idx_d = drain_idx_q + IW'(1);
                    end
                end
            end
        endcase
    end

    // A timeout in the same cycle as err_clr leaves the flag set.
    assign err_d = timeout | (err_q & ~err_clr);

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (r) begin
            state_q     <= ST_LOAD;
            load_idx_q  <= '0;
            drain_idx_q <= '0;
            wait_cnt_q  <= '0;
            dpv_prev_q  <= 1'b0;
            err_q       <= 1'b0;
            frames_q    <= '0;
        end else begin
            state_q     <= state_d;
            load_idx_q  <= load_idx_d;
            drain_idx_q <= drain_idx_d;
            wait_cnt_q  <= wait_cnt_d;
            dpv_prev_q  <= dp_valid_out;
            err_q       <= err_d;
            frames_q    <= frames_d;
        end
    end

endmodule

// File: tb/tb_intt_stream_ctrl.sv
// Self-checking bench for intt_stream_ctrl with a D=3 datapath model.
// Latency: not applicable.
// Backpressure: drives m_ready constant, 1-0-0 pattern or random.
module tb_intt_stream_ctrl;

    localparam int W       = 12;
    localparam int N       = 8;
    localparam int TIMEOUT = 32;

    typedef logic [N-1:0][W-1:0] vec_w_t;

    typedef struct {
        vec_w_t din;
        int     hold;      // cycles the model holds valid high (0 = never)
        int     rdy;       // m_ready mode: 0 always, 1 pattern 1,0,0, 2 random
        logic   force_hi;  // valid held high before and through the frame
        logic   clr_w;     // err_clr asserted while busy
        logic   exp_err;
        int     exp_lat;   // 0 = latency not checked
    } vec_t;

    logic         clk = 1'b0;
    logic         r;
    logic         s_valid;
    logic [W-1:0] s_data;
    logic         s_ready;
    logic         m_valid;
    logic [W-1:0] m_data;
    logic         m_ready;
    vec_w_t       dp_coeffs;
    logic         dp_valid_in;
    vec_w_t       dp_coeffs_out;
    logic         dp_valid_out;
    logic         busy;
    logic         err;
    logic         err_clr;
    logic [15:0]  frames_done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    intt_stream_ctrl #(.W(W), .N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .r             (r),
        .s_valid       (s_valid),
        .s_data        (s_data),
        .s_ready       (s_ready),
        .m_valid       (m_valid),
        .m_data        (m_data),
        .m_ready       (m_ready),
        .dp_coeffs     (dp_coeffs),
        .dp_valid_in   (dp_valid_in),
        .dp_coeffs_out (dp_coeffs_out),
        .dp_valid_out  (dp_valid_out),
        .busy          (busy),
        .err           (err),
        .err_clr       (err_clr),
        .frames_done   (frames_done)
    );

    // The transform the datapath model applies.
    function automatic vec_w_t dp_func(input vec_w_t c);
        vec_w_t res;
        for (int i = 0; i < N; i++) res[i] = W'((int'(c[i]) * 7 + i + 1) % 3329);
        return res;
    endfunction

    // Datapath model: valid appears 3 cycles after the start pulse, held for dp_hold cycles.
    logic [2:0] pipe = '0;
    int         hold_cnt = 0;
    int         dp_hold = 1;
    logic       force_hi = 1'b0;
    vec_w_t     dp_res = '0;
    always @(posedge clk) begin
        pipe <= {pipe[1:0], dp_valid_in};
        if (dp_valid_in) dp_res <= dp_func(dp_coeffs);
        if (pipe[1]) hold_cnt <= dp_hold;
        else if (hold_cnt != 0) hold_cnt <= hold_cnt - 1;
    end
    assign dp_valid_out  = force_hi | (hold_cnt != 0);
    assign dp_coeffs_out = dp_res;

    logic clr_req = 1'b0;
    logic clr_w   = 1'b0;
    assign err_clr = clr_req | (clr_w & busy);

    // m_ready driver.
    int rdy_mode = 0;
    int ph = 0;
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_ready = 1'b1;
                1:       begin m_ready = (ph % 3 == 0); ph++; end
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor, sampled on the falling edge.
    int           cyc = 0;
    int           last_in_cyc, first_out_cyc, fire_cyc, err_cyc;
    int           pulses = 0;
    int           overlap = 0;
    int           stall_bad = 0;
    logic         err_seen = 1'b0;
    logic         stall_pend = 1'b0;
    logic [W-1:0] stall_dat;
    vec_w_t       dp_seen;
    logic [W-1:0] got_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (s_valid && s_ready) last_in_cyc = cyc;
        if (dp_valid_in) begin pulses++; fire_cyc = cyc; dp_seen = dp_coeffs; end
        if (m_valid && m_ready) begin
            got_q.push_back(m_data);
            if (got_q.size() == 1) first_out_cyc = cyc;
        end
        if (s_ready && m_valid) overlap++;
        if (stall_pend && m_valid && (m_data !== stall_dat)) stall_bad++;
        stall_pend = m_valid && !m_ready;
        stall_dat  = m_data;
        if (err && !err_seen) begin err_seen = 1'b1; err_cyc = cyc; end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_beats(input vec_w_t d, input int cnt, input logic gaps);
        for (int i = 0; i < cnt; i++) begin
            int n = 0;
            if (gaps) begin
                s_valid = 1'b0;
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            s_valid = 1'b1;
            s_data  = d[i];
            while (1) begin
                @(negedge clk);
                if (s_ready) break;
                n++;
                if (n > 300) begin
                    checks++; errors++;
                    $display("FAIL s_ready_wait: got no s_ready, expected s_ready within 300 cycles");
                    break;
                end
            end
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!(got_q.size() >= N || err_seen) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            checks++; errors++;
            $display("FAIL frame_wait: got %0d beats err=%0b, expected frame end within 400 cycles",
                     got_q.size(), err);
        end
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    int exp_frames = 0;

    task automatic run_vec(input vec_t v, input logic gaps);
        vec_w_t exp;
        got_q.delete();
        pulses   = 0;
        err_seen = 1'b0;
        dp_hold  = v.hold;
        rdy_mode = v.rdy;
        force_hi = v.force_hi;
        clr_w    = v.clr_w;
        send_beats(v.din, N, gaps);
        wait_done();
        force_hi = 1'b0;
        clr_w    = 1'b0;
        chk("dp_pulses", pulses, 1);
        chk("dp_coeffs", dp_seen, v.din);
        if (v.exp_err) begin
            chk("timeout_err", err, 1);
            chk("timeout_beats", got_q.size(), 0);
            chk("timeout_in_load", busy, 0);
            chk("timeout_frames", frames_done, exp_frames);
            chk("timeout_cycles", err_cyc - fire_cyc, TIMEOUT + 1);
            clr_req = 1'b1;
            @(posedge clk); #1;
            clr_req = 1'b0;
            @(negedge clk);
            chk("err_clr", err, 0);
            @(posedge clk); #1;
        end else begin
            exp = dp_func(v.din);
            exp_frames++;
            chk("beats", got_q.size(), N);
            for (int i = 0; i < got_q.size() && i < N; i++) chk("beat_data", got_q[i], exp[i]);
            chk("frames_done", frames_done, exp_frames);
            chk("no_err", err, 0);
            if (v.exp_lat != 0) chk("latency", first_out_cyc - last_in_cyc, v.exp_lat);
        end
    endtask

    vec_t   tbl[7];
    vec_t   rv;
    vec_w_t part;

    initial begin
        // Directed table.
        for (int k = 0; k < 7; k++) begin
            tbl[k].hold = 1; tbl[k].rdy = 0; tbl[k].force_hi = 0;
            tbl[k].clr_w = 0; tbl[k].exp_err = 0; tbl[k].exp_lat = 0;
        end
        for (int i = 0; i < N; i++) begin
            tbl[0].din[i] = W'(i + 1);
            tbl[1].din[i] = W'(i * 500 + 7);
            tbl[2].din[i] = (i % 2 == 0) ? 12'hFFF : 12'h000;
            tbl[3].din[i] = W'(i * 3);
            tbl[4].din[i] = W'(i + 40);
            tbl[5].din[i] = W'(i * 11 + 2);
            tbl[6].din[i] = W'(3328 - i);
        end
        tbl[0].exp_lat = 5;
        tbl[1].hold = 4;
        tbl[2].rdy = 1;
        tbl[3].hold = 0; tbl[3].exp_err = 1;
        tbl[4].force_hi = 1; tbl[4].exp_err = 1;
        tbl[5].hold = 0; tbl[5].clr_w = 1; tbl[5].exp_err = 1;
        tbl[6].hold = 2; tbl[6].rdy = 2;

        // Reset behaviour.
        r = 1'b1; s_valid = 1'b0; s_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_dp_valid_in", dp_valid_in, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_err", err, 0);
        chk("rst_frames", frames_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dp_coeffs", dp_coeffs, 0);
        @(posedge clk); #1;
        r = 1'b0;
        @(negedge clk);
        chk("post_rst_s_ready", s_ready, 1);
        @(posedge clk); #1;

        for (int k = 0; k < 7; k++) run_vec(tbl[k], 1'b0);

        // Reset in the middle of a frame load.
        for (int i = 0; i < N; i++) part[i] = W'(900 + i);
        rdy_mode = 0;
        send_beats(part, 5, 1'b0);
        r = 1'b1;
        @(negedge clk);
        chk("midload_rst_s_ready", s_ready, 0);
        chk("midload_rst_m_valid", m_valid, 0);
        @(posedge clk); #1;
        r = 1'b0;
        exp_frames = 0;
        @(negedge clk);
        chk("midload_s_ready", s_ready, 1);
        chk("midload_frames", frames_done, 0);
        @(posedge clk); #1;
        run_vec(tbl[0], 1'b0);

        // Reset in the middle of draining a frame.
        got_q.delete();
        dp_hold = 1; rdy_mode = 0;
        send_beats(tbl[1].din, N, 1'b0);
        for (int n = 0; n < 100 && got_q.size() < 3; n++) @(negedge clk);
        r = 1'b1;
        @(posedge clk); #1;
        r = 1'b0;
        exp_frames = 0;
        repeat (20) @(negedge clk);
        chk("middrain_beats", got_q.size(), 3);
        chk("middrain_frames", frames_done, 0);
        chk("middrain_m_valid", m_valid, 0);
        chk("middrain_s_ready", s_ready, 1);
        @(posedge clk); #1;

        // Random back-to-back frames with random gaps and backpressure.
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < N; i++) rv.din[i] = W'($urandom_range(0, 4095));
            rv.hold = $urandom_range(1, 4); rv.rdy = 2;
            rv.force_hi = 0; rv.clr_w = 0; rv.exp_err = 0; rv.exp_lat = 0;
            run_vec(rv, 1'b1);
        end

        chk("final_frames", frames_done, exp_frames);
        chk("no_overlap", overlap, 0);
        chk("stall_stable", stall_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
